// File: rtl/stream_supervisor.sv
// stream_supervisor: walks an I2S streaming datapath through PLL lock, frame sync and FIFO prefill, and recovers from FIFO faults.
// Define STREAM_SUPERVISOR_ERRCNT_EN to build the saturating underrun/overflow counters; without it the counter ports read 0.
module stream_supervisor #(
  parameter int LOCK_CYCLES   = 1024,
  parameter int SYNC_FRAMES   = 2,
  parameter int PREFILL_LEVEL = 8,
  parameter int LEVEL_W       = 5,
  parameter int FAULT_CYCLES  = 64,
  parameter int CNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               user_sw,
  input  logic               fclk,
  input  logic [LEVEL_W-1:0] fifo_level,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               write_en,
  output logic               read_en,
  output logic               sys_rst,
  output logic               led_red,
  output logic               led_green,
  output logic               led_blue,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   underrun_cnt,
  output logic [CNT_W-1:0]   overflow_cnt
);

  localparam int TMR_MAX0 = (LOCK_CYCLES > FAULT_CYCLES) ? LOCK_CYCLES : FAULT_CYCLES;
  localparam int TMR_MAX  = (TMR_MAX0 > SYNC_FRAMES) ? TMR_MAX0 : SYNC_FRAMES;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]   LOCK_LAST   = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]   FRAME_LAST  = TMR_W'(SYNC_FRAMES - 1);
  localparam logic [TMR_W-1:0]   FAULT_LAST  = TMR_W'(FAULT_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] PREFILL_LVL = LEVEL_W'(PREFILL_LEVEL);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOCKWAIT = 3'd1,
    SYNC     = 3'd2,
    PREFILL  = 3'd3,
    RUN      = 3'd4,
    FAULT    = 3'd5
  } state_t;

  // Synchronizer bit order: {pll_lock, user_sw, fclk}
  logic [2:0]       meta_q, meta_d;
  logic [2:0]       sync_q, sync_d;
  logic             fclk_prev_q, fclk_prev_d;
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       out_q, out_d;

  logic lock_s, sw_s, fclk_fall;
  logic tmr_inc, uf_hit, of_hit;

  // {sys_rst, led_red, led_green, led_blue}; LEDs are active-low
  function automatic logic [3:0] decode_out(input state_t s);
    case (s)
      LOCKWAIT, FAULT: return 4'b1011;
      SYNC, PREFILL:   return 4'b0110;
      RUN:             return 4'b0101;
      default:         return 4'b1111;
    endcase
  endfunction

  assign lock_s    = sync_q[2];
  assign sw_s      = sync_q[1];
  assign fclk_fall = fclk_prev_q & ~sync_q[0];

  always_comb begin
    meta_d      = {pll_lock, user_sw, fclk};
    sync_d      = meta_q;
    fclk_prev_d = sync_q[0];
    state_d     = state_q;
    tmr_inc     = 1'b0;
    uf_hit      = 1'b0;
    of_hit      = 1'b0;
    if (state_q > FAULT) begin
      state_d = IDLE;
    end else if (!sw_s) begin
      state_d = IDLE;
    end else if (!lock_s && state_q != IDLE) begin
      state_d = LOCKWAIT;
    end else if (state_q == RUN && (fifo_empty || fifo_full)) begin
      state_d = FAULT;
      uf_hit  = fifo_empty;
      of_hit  = fifo_full;
    end else begin
      case (state_q)
        IDLE:     state_d = LOCKWAIT;
        LOCKWAIT: begin
          if (tmr_q == LOCK_LAST) state_d = SYNC;
          else                    tmr_inc = 1'b1;
        end
        SYNC: begin
          if (fclk_fall) begin
            if (tmr_q == FRAME_LAST) state_d = PREFILL;
            else                     tmr_inc = 1'b1;
          end
        end
        PREFILL:  if (fifo_level >= PREFILL_LVL) state_d = RUN;
        FAULT: begin
          if (tmr_q == FAULT_LAST) state_d = SYNC;
          else                     tmr_inc = 1'b1;
        end
        default:  state_d = state_q;
      endcase
    end
    // One timer serves lock, frame and fault counting; it restarts on every state change and on any lock drop
    if (state_d != state_q || !lock_s) tmr_d = '0;
    else if (tmr_inc)                  tmr_d = tmr_q + 1'b1;
    else                               tmr_d = tmr_q;
    out_d = decode_out(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      fclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      tmr_q       <= '0;
      out_q       <= 4'b1111;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      fclk_prev_q <= fclk_prev_d;
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      out_q       <= out_d;
    end
  end

  assign state     = state_q;
  assign write_en  = (state_q == PREFILL || state_q == RUN) && !fifo_full;
  assign read_en   = (state_q == RUN) && !fifo_empty;
  assign sys_rst   = out_q[3];
  assign led_red   = out_q[2];
  assign led_green = out_q[1];
  assign led_blue  = out_q[0];

`ifdef STREAM_SUPERVISOR_ERRCNT_EN
  logic [CNT_W-1:0] uf_cnt_q, uf_cnt_d, of_cnt_q, of_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    if (hit && v != {CNT_W{1'b1}}) return v + 1'b1;
    return v;
  endfunction

  // Counters survive user_sw and lock loss; only rst clears them
  always_comb begin
    uf_cnt_d = sat_inc(uf_cnt_q, uf_hit);
    of_cnt_d = sat_inc(of_cnt_q, of_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uf_cnt_q <= '0;
      of_cnt_q <= '0;
    end else begin
      uf_cnt_q <= uf_cnt_d;
      of_cnt_q <= of_cnt_d;
    end
  end

  assign underrun_cnt = uf_cnt_q;
  assign overflow_cnt = of_cnt_q;
`else
  logic unused_hits;
  assign unused_hits  = uf_hit ^ of_hit;
  assign underrun_cnt = '0;
  assign overflow_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_supervisor.sv
// Scoreboard bench for stream_supervisor with short lock/fault timings; counter expectations follow STREAM_SUPERVISOR_ERRCNT_EN.
module tb_stream_supervisor;
  localparam int LEVEL_W = 5;
  localparam int CNT_W   = 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOCKWAIT = 3'd1, S_SYNC = 3'd2,
                         S_PREFILL = 3'd3, S_RUN = 3'd4, S_FAULT = 3'd5;
`ifdef STREAM_SUPERVISOR_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, pll_lock, user_sw, fclk, fifo_full, fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic write_en, read_en, sys_rst, led_red, led_green, led_blue;
  logic [2:0] state;
  logic [CNT_W-1:0] underrun_cnt, overflow_cnt;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       name;
    logic [31:0] v;
  } item_t;
  item_t       exp_q[$];
  logic [31:0] obs_q[$];

  stream_supervisor #(
    .LOCK_CYCLES(16), .SYNC_FRAMES(2), .PREFILL_LEVEL(4),
    .LEVEL_W(LEVEL_W), .FAULT_CYCLES(8), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .user_sw(user_sw), .fclk(fclk),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .write_en(write_en), .read_en(read_en), .sys_rst(sys_rst),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue),
    .state(state), .underrun_cnt(underrun_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  function automatic logic [31:0] leds();
    return {29'd0, led_red, led_green, led_blue};
  endfunction

  task automatic exp_push(input string n, input logic [31:0] v);
    exp_q.push_back('{n, v});
  endtask

  task automatic observe(input logic [31:0] v);
    obs_q.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, output int n);
    n = 0;
    while (state !== tgt && n < budget) begin
      tick();
      n++;
    end
    if (state !== tgt) n = -1;
  endtask

  task automatic frame();
    fclk = 1'b1;
    repeat (4) tick();
    fclk = 1'b0;
    repeat (4) tick();
  endtask

  task automatic goto_run(output bit ok);
    int n1, n2;
    wait_state(S_SYNC, 40, n1);
    frame();
    frame();
    wait_state(S_RUN, 10, n2);
    ok = (n1 >= 0) && (n2 >= 0);
  endtask

  task automatic test_reset();
    item_t e;
    logic [31:0] o;
    rst = 1'b1; pll_lock = 1'b0; user_sw = 1'b0; fclk = 1'b0;
    fifo_level = '0; fifo_full = 1'b0; fifo_empty = 1'b0;
    repeat (3) tick();
    exp_push("rst_state", S_IDLE);     observe(state);
    exp_push("rst_sys_rst", 1);        observe(sys_rst);
    exp_push("rst_write_en", 0);       observe(write_en);
    exp_push("rst_read_en", 0);        observe(read_en);
    exp_push("rst_leds", 3'b111);      observe(leds());
    exp_push("rst_underrun", 0);       observe(underrun_cnt);
    exp_push("rst_overflow", 0);       observe(overflow_cnt);
    rst = 1'b0;
    repeat (4) tick();
    exp_push("idle_sw_low", S_IDLE);   observe(state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_bringup();
    item_t e;
    logic [31:0] o;
    int n;
    user_sw = 1'b1; pll_lock = 1'b1;
    // two synchronizer stages plus the state register
    wait_state(S_LOCKWAIT, 10, n);
    exp_push("idle_to_lockwait", 3);    observe(n);
    exp_push("lockwait_leds", 3'b011);  observe(leds());
    exp_push("lockwait_sys_rst", 1);    observe(sys_rst);
    wait_state(S_SYNC, 40, n);
    exp_push("lock_cycles", 16);        observe(n);
    exp_push("sync_leds", 3'b110);      observe(leds());
    exp_push("sync_write_en", 0);       observe(write_en);
    frame();
    exp_push("one_fall_still_sync", S_SYNC); observe(state);
    frame();
    exp_push("two_falls_prefill", S_PREFILL); observe(state);
    exp_push("prefill_write_en", 1);    observe(write_en);
    exp_push("prefill_read_en", 0);     observe(read_en);
    exp_push("prefill_sys_rst", 0);     observe(sys_rst);
    fifo_level = 5'd3;
    repeat (3) tick();
    exp_push("level3_stays_prefill", S_PREFILL); observe(state);
    fifo_level = 5'd4;
    wait_state(S_RUN, 10, n);
    exp_push("level4_to_run", 1);       observe(n);
    exp_push("run_read_en", 1);         observe(read_en);
    exp_push("run_write_en", 1);        observe(write_en);
    exp_push("run_leds", 3'b101);       observe(leds());
    fifo_full = 1'b1; #1;
    exp_push("run_full_write_en", 0);   observe(write_en);
    fifo_full = 1'b0; fifo_empty = 1'b1; #1;
    exp_push("run_empty_read_en", 0);   observe(read_en);
    fifo_empty = 1'b0;
    tick();
    exp_push("run_holds", S_RUN);       observe(state);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_lock_glitch();
    item_t e;
    logic [31:0] o;
    int n;
    user_sw = 1'b0;
    wait_state(S_IDLE, 10, n);
    exp_push("sw_low_to_idle", 3);      observe(n);
    user_sw = 1'b1;
    wait_state(S_LOCKWAIT, 10, n);
    exp_push("reenter_lockwait", 3);    observe(n);
    repeat (10) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    exp_push("glitch_in_lockwait", S_LOCKWAIT); observe(state);
    // 2 synchronizer cycles before the restarted 16-cycle lock count begins
    wait_state(S_SYNC, 40, n);
    exp_push("glitch_restart_cycles", 18); observe(n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_underrun();
    item_t e;
    logic [31:0] o;
    bit ok;
    int n, hi;
    goto_run(ok);
    exp_push("underrun_reach_run", 1);  observe(ok);
    fifo_empty = 1'b1;
    tick();
    fifo_empty = 1'b0;
    exp_push("underrun_fault", S_FAULT); observe(state);
    exp_push("fault_leds", 3'b011);     observe(leds());
    exp_push("fault_write_en", 0);      observe(write_en);
    n = 0; hi = 0;
    while (state !== S_SYNC && n < 20) begin
      if (sys_rst === 1'b1) hi++;
      tick();
      n++;
    end
    exp_push("fault_to_sync_cycles", 8); observe(n);
    exp_push("fault_sys_rst_cycles", 8); observe(hi);
    exp_push("after_fault_sys_rst", 0);  observe(sys_rst);
    exp_push("underrun_cnt_1", exp_cnt(1)); observe(underrun_cnt);
    exp_push("overflow_cnt_0", exp_cnt(0)); observe(overflow_cnt);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_both_flags();
    item_t e;
    logic [31:0] o;
    bit ok;
    int bad;
    goto_run(ok);
    exp_push("both_reach_run", 1);      observe(ok);
    fifo_full = 1'b1; fifo_empty = 1'b1;
    tick();
    fifo_full = 1'b0; fifo_empty = 1'b0;
    exp_push("both_fault", S_FAULT);    observe(state);
    exp_push("both_underrun_2", exp_cnt(2)); observe(underrun_cnt);
    exp_push("both_overflow_1", exp_cnt(1)); observe(overflow_cnt);
    bad = 0;
    repeat (299) begin
      goto_run(ok);
      if (!ok) bad++;
      fifo_full = 1'b1; fifo_empty = 1'b1;
      tick();
      fifo_full = 1'b0; fifo_empty = 1'b0;
    end
    exp_push("sat_loop_run_failures", 0); observe(bad);
    exp_push("sat_underrun_255", exp_cnt(255)); observe(underrun_cnt);
    exp_push("sat_overflow_255", exp_cnt(255)); observe(overflow_cnt);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_priority();
    item_t e;
    logic [31:0] o;
    bit ok;
    int n;
    goto_run(ok);
    exp_push("prio_reach_run", 1);      observe(ok);
    user_sw = 1'b0; pll_lock = 1'b0;
    wait_state(S_IDLE, 10, n);
    exp_push("prio_idle_cycles", 3);    observe(n);
    exp_push("prio_leds_off", 3'b111);  observe(leds());
    exp_push("prio_sys_rst", 1);        observe(sys_rst);
    exp_push("prio_underrun_kept", exp_cnt(255)); observe(underrun_cnt);
    exp_push("prio_overflow_kept", exp_cnt(255)); observe(overflow_cnt);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_lock_loss();
    item_t e;
    logic [31:0] o;
    bit ok;
    int n;
    user_sw = 1'b1; pll_lock = 1'b1;
    goto_run(ok);
    exp_push("loss_reach_run", 1);      observe(ok);
    pll_lock = 1'b0;
    wait_state(S_LOCKWAIT, 10, n);
    exp_push("loss_to_lockwait", 3);    observe(n);
    exp_push("loss_leds", 3'b011);      observe(leds());
    exp_push("loss_read_en", 0);        observe(read_en);
    exp_push("loss_underrun_kept", exp_cnt(255)); observe(underrun_cnt);
    pll_lock = 1'b1;
    wait_state(S_SYNC, 40, n);
    exp_push("relock_cycles", 18);      observe(n);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    item_t e;
    logic [31:0] o;
    exp_push("pre_rst_state", S_SYNC);  observe(state);
    rst = 1'b1;
    #2;
    exp_push("async_rst_state", S_IDLE); observe(state);
    exp_push("async_rst_sys_rst", 1);    observe(sys_rst);
    exp_push("async_rst_leds", 3'b111);  observe(leds());
    exp_push("async_rst_underrun", 0);   observe(underrun_cnt);
    exp_push("async_rst_overflow", 0);   observe(overflow_cnt);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hx;
      vectors++;
      if (o !== e.v) begin
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.v);
        miscompares++;
      end
    end
    obs_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_bringup();
    test_lock_glitch();
    test_underrun();
    test_both_flags();
    test_priority();
    test_lock_loss();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
